// File: rtl/uc1611_pkg.sv
// Shared definitions for the UC1611 bus responder: opcode constants and masks,
// the argument-state enum, register reset defaults and the opcode classifier.
package uc1611_pkg;

   typedef enum logic [1:0] {
      ARG_NONE,
      ARG_GAIN,
      ARG_APC
   } arg_state_e;

   typedef enum logic [4:0] {
      OP_COL_LSB,
      OP_COL_MSB,
      OP_PANEL_PC,
      OP_SCROLL_LSB,
      OP_SCROLL_MSB,
      OP_PAGE_LSB,
      OP_PAGE_MSB,
      OP_GAIN,
      OP_PARTIAL,
      OP_RAM_AC,
      OP_LINE_RATE,
      OP_DISP_EN,
      OP_MAP_CTL,
      OP_GRAY_LC,
      OP_BIAS,
      OP_APC,
      OP_NOP,
      OP_SYS_RESET,
      OP_UNKNOWN
   } op_e;

   // Mask width names the number of low argument bits carried in the opcode.
   localparam logic [7:0] MASK_ARG4  = 8'hF0;
   localparam logic [7:0] MASK_ARG3  = 8'hF8;
   localparam logic [7:0] MASK_ARG2  = 8'hFC;
   localparam logic [7:0] MASK_ARG1  = 8'hFE;
   localparam logic [7:0] MASK_EXACT = 8'hFF;

   localparam logic [7:0] OPC_COL_LSB    = 8'h00;
   localparam logic [7:0] OPC_COL_MSB    = 8'h10;
   localparam logic [7:0] OPC_PANEL_PC   = 8'h28;
   localparam logic [7:0] OPC_APC        = 8'h30;
   localparam logic [7:0] OPC_SCROLL_LSB = 8'h40;
   localparam logic [7:0] OPC_SCROLL_MSB = 8'h50;
   localparam logic [7:0] OPC_PAGE_LSB   = 8'h60;
   localparam logic [7:0] OPC_PAGE_MSB   = 8'h70;
   localparam logic [7:0] OPC_GAIN       = 8'h81;
   localparam logic [7:0] OPC_PARTIAL    = 8'h84;
   localparam logic [7:0] OPC_RAM_AC     = 8'h88;
   localparam logic [7:0] OPC_LINE_RATE  = 8'hA0;
   localparam logic [7:0] OPC_DISP_EN    = 8'hA8;
   localparam logic [7:0] OPC_MAP_CTL    = 8'hC0;
   localparam logic [7:0] OPC_GRAY_LC    = 8'hD0;
   localparam logic [7:0] OPC_SYS_RESET  = 8'hE2;
   localparam logic [7:0] OPC_NOP        = 8'hE3;
   localparam logic [7:0] OPC_BIAS       = 8'hE8;

   localparam logic [1:0] BIAS_RESET   = 2'b11;
   localparam logic [2:0] RAM_AC_RESET = 3'b001;

   function automatic logic opc_match(input logic [7:0] b, input logic [7:0] value,
                                      input logic [7:0] mask);
      return (b & mask) == value;
   endfunction

   function automatic op_e decode_op(input logic [7:0] b);
      op_e op;
      if      (opc_match(b, OPC_COL_LSB,    MASK_ARG4))  op = OP_COL_LSB;
      else if (opc_match(b, OPC_COL_MSB,    MASK_ARG4))  op = OP_COL_MSB;
      else if (opc_match(b, OPC_PANEL_PC,   MASK_ARG2))  op = OP_PANEL_PC;
      else if (opc_match(b, OPC_APC,        MASK_ARG1))  op = OP_APC;
      else if (opc_match(b, OPC_SCROLL_LSB, MASK_ARG4))  op = OP_SCROLL_LSB;
      else if (opc_match(b, OPC_SCROLL_MSB, MASK_ARG4))  op = OP_SCROLL_MSB;
      else if (opc_match(b, OPC_PAGE_LSB,   MASK_ARG4))  op = OP_PAGE_LSB;
      else if (opc_match(b, OPC_PAGE_MSB,   MASK_ARG3))  op = OP_PAGE_MSB;
      else if (opc_match(b, OPC_GAIN,       MASK_EXACT)) op = OP_GAIN;
      else if (opc_match(b, OPC_PARTIAL,    MASK_ARG2))  op = OP_PARTIAL;
      else if (opc_match(b, OPC_RAM_AC,     MASK_ARG3))  op = OP_RAM_AC;
      else if (opc_match(b, OPC_LINE_RATE,  MASK_ARG2))  op = OP_LINE_RATE;
      else if (opc_match(b, OPC_DISP_EN,    MASK_ARG3))  op = OP_DISP_EN;
      else if (opc_match(b, OPC_MAP_CTL,    MASK_ARG3))  op = OP_MAP_CTL;
      else if (opc_match(b, OPC_GRAY_LC,    MASK_ARG2))  op = OP_GRAY_LC;
      else if (opc_match(b, OPC_BIAS,       MASK_ARG2))  op = OP_BIAS;
      else if (opc_match(b, OPC_NOP,        MASK_EXACT)) op = OP_NOP;
      else if (opc_match(b, OPC_SYS_RESET,  MASK_EXACT)) op = OP_SYS_RESET;
      else                                               op = OP_UNKNOWN;
      return op;
   endfunction

endpackage

// File: rtl/uc1611_addr_gen.sv
// Page/column address counters with nibble loads, range check and the
// UC1611 column-first / page-first auto-increment with wrap.
module uc1611_addr_gen #(
   parameter int COLS  = 160,
   parameter int PAGES = 72
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load_col_lsb,
   input  logic       load_col_msb,
   input  logic       load_page_lsb,
   input  logic       load_page_msb,
   input  logic [3:0] load_val,
   input  logic       advance,
   input  logic [1:0] ac,
   output logic [6:0] cur_page,
   output logic [7:0] cur_col,
   output logic       in_range
);

   localparam logic [7:0] COL_LAST  = 8'(COLS - 1);
   localparam logic [6:0] PAGE_LAST = 7'(PAGES - 1);

   logic       col_wrap;
   logic       page_wrap;
   logic [7:0] col_step;
   logic [6:0] page_step;

   // Out-of-range counters never equal the last index, so they roll over naturally.
   assign col_wrap  = (cur_col == COL_LAST);
   assign page_wrap = (cur_page == PAGE_LAST);
   assign col_step  = col_wrap  ? 8'd0 : cur_col + 8'd1;
   assign page_step = page_wrap ? 7'd0 : cur_page + 7'd1;
   assign in_range  = (int'(cur_col) < COLS) && (int'(cur_page) < PAGES);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, as the hardware does.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_col  <= '0;
         cur_page <= '0;
      end else if (clear) begin
         cur_col  <= '0;
         cur_page <= '0;
      end else begin
         if (load_col_lsb)  cur_col[3:0]  <= load_val;
         if (load_col_msb)  cur_col[7:4]  <= load_val;
         if (load_page_lsb) cur_page[3:0] <= load_val;
         if (load_page_msb) cur_page[6:4] <= load_val[2:0];
         if (advance) begin
            if (!ac[1]) begin
               cur_col <= col_step;
               if (col_wrap && ac[0]) cur_page <= page_step;
            end else begin
               cur_page <= page_step;
               if (page_wrap && ac[0]) cur_col <= col_step;
            end
         end
      end
   end

endmodule

// File: rtl/uc1611_bus_rx.sv
// UC1611 parallel-bus responder: edge-detects write strobes, decodes commands
// into configuration registers and turns data bytes into framebuffer writes.
module uc1611_bus_rx
   import uc1611_pkg::*;
#(
   parameter int COLS  = 160,
   parameter int PAGES = 72
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] lcd_data,
   input  logic       lcd_cd,
   input  logic       lcd_write,
   input  logic       lcd_read,
   input  logic       lcd_cs,
   output logic       fb_we,
   output logic [6:0] fb_page,
   output logic [7:0] fb_col,
   output logic [7:0] fb_data,
   output logic [6:0] cur_page,
   output logic [7:0] cur_col,
   output logic [7:0] scroll,
   output logic [1:0] gray_lc,
   output logic [2:0] map_ctl,
   output logic [1:0] bias,
   output logic [1:0] panel_pc,
   output logic [1:0] gain,
   output logic [5:0] pot,
   output logic [1:0] line_rate,
   output logic [1:0] partial,
   output logic [2:0] ram_ac,
   output logic [7:0] apc,
   output logic [2:0] disp_en,
   output logic       cmd_err
);

   arg_state_e arg_state;
   op_e        op;
   logic       write_q;
   logic       read_q;
   logic       accept;
   logic       read_edge;
   logic       is_cmd;
   logic       is_data;
   logic       cmd_live;
   logic       in_range;
   logic       sys_reset;
   logic       load_col_lsb;
   logic       load_col_msb;
   logic       load_page_lsb;
   logic       load_page_msb;

   // Strobes count only on their own rising edge while selected; a chip select
   // arriving under an already-high strobe therefore never accepts.
   assign accept    = lcd_write && !write_q && lcd_cs;
   assign read_edge = lcd_read && !read_q && lcd_cs;
   assign is_cmd    = accept && !lcd_cd;
   assign is_data   = accept && lcd_cd;
   assign cmd_live  = is_cmd && (arg_state == ARG_NONE);
   assign op        = decode_op(lcd_data);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      load_col_lsb  = 1'b0;
      load_col_msb  = 1'b0;
      load_page_lsb = 1'b0;
      load_page_msb = 1'b0;
      sys_reset     = 1'b0;
      if (cmd_live) begin
         unique case (op)
            OP_COL_LSB:   load_col_lsb  = 1'b1;
            OP_COL_MSB:   load_col_msb  = 1'b1;
            OP_PAGE_LSB:  load_page_lsb = 1'b1;
            OP_PAGE_MSB:  load_page_msb = 1'b1;
            OP_SYS_RESET: sys_reset     = 1'b1;
            default:      ;
         endcase
      end
   end

   uc1611_addr_gen #(
      .COLS  (COLS),
      .PAGES (PAGES)
   ) u_addr_gen (
      .clk           (clk),
      .reset         (reset),
      .clear         (sys_reset),
      .load_col_lsb  (load_col_lsb),
      .load_col_msb  (load_col_msb),
      .load_page_lsb (load_page_lsb),
      .load_page_msb (load_page_msb),
      .load_val      (lcd_data[3:0]),
      .advance       (is_data),
      .ac            (ram_ac[1:0]),
      .cur_page      (cur_page),
      .cur_col       (cur_col),
      .in_range      (in_range)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q   <= 1'b0;
         read_q    <= 1'b0;
         arg_state <= ARG_NONE;
         fb_we     <= 1'b0;
         fb_page   <= '0;
         fb_col    <= '0;
         fb_data   <= '0;
         scroll    <= '0;
         gray_lc   <= '0;
         map_ctl   <= '0;
         bias      <= BIAS_RESET;
         panel_pc  <= '0;
         gain      <= '0;
         pot       <= '0;
         line_rate <= '0;
         partial   <= '0;
         ram_ac    <= RAM_AC_RESET;
         apc       <= '0;
         disp_en   <= '0;
         cmd_err   <= 1'b0;
      end else begin
         write_q <= lcd_write;
         read_q  <= lcd_read;
         fb_we   <= 1'b0;
         cmd_err <= read_edge;

         if (is_data) begin
            // A data byte aborts any pending argument, then is written as data.
            if (arg_state != ARG_NONE) begin
               cmd_err   <= 1'b1;
               arg_state <= ARG_NONE;
            end
            if (in_range) begin
               fb_we   <= 1'b1;
               fb_page <= cur_page;
               fb_col  <= cur_col;
               fb_data <= lcd_data;
            end
         end else if (is_cmd) begin
            unique case (arg_state)
               ARG_GAIN: begin
                  gain      <= lcd_data[7:6];
                  pot       <= lcd_data[5:0];
                  arg_state <= ARG_NONE;
               end
               ARG_APC: begin
                  apc       <= lcd_data;
                  arg_state <= ARG_NONE;
               end
               default: begin
                  unique case (op)
                     OP_PANEL_PC:   panel_pc     <= lcd_data[1:0];
                     OP_SCROLL_LSB: scroll[3:0]  <= lcd_data[3:0];
                     OP_SCROLL_MSB: scroll[7:4]  <= lcd_data[3:0];
                     OP_GAIN:       arg_state    <= ARG_GAIN;
                     OP_APC:        arg_state    <= ARG_APC;
                     OP_PARTIAL:    partial      <= lcd_data[1:0];
                     OP_RAM_AC:     ram_ac       <= lcd_data[2:0];
                     OP_LINE_RATE:  line_rate    <= lcd_data[1:0];
                     OP_DISP_EN:    disp_en      <= lcd_data[2:0];
                     OP_MAP_CTL:    map_ctl      <= lcd_data[2:0];
                     OP_GRAY_LC:    gray_lc      <= lcd_data[1:0];
                     OP_BIAS:       bias         <= lcd_data[1:0];
                     OP_UNKNOWN:    cmd_err      <= 1'b1;
                     OP_SYS_RESET: begin
                        fb_page   <= '0;
                        fb_col    <= '0;
                        fb_data   <= '0;
                        scroll    <= '0;
                        gray_lc   <= '0;
                        map_ctl   <= '0;
                        bias      <= BIAS_RESET;
                        panel_pc  <= '0;
                        gain      <= '0;
                        pot       <= '0;
                        line_rate <= '0;
                        partial   <= '0;
                        ram_ac    <= RAM_AC_RESET;
                        apc       <= '0;
                        disp_en   <= '0;
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uc1611_bus_rx.md
# uc1611_bus_rx

Responder side of the UC1611 8-bit parallel write bus: the panel-controller model that the LCD driver talks to. It samples the bus and decodes command bytes, including the two-byte commands, into the controller's configuration registers. It turns data bytes into framebuffer write strobes with UC1611 page/column auto-increment. It sits between the LCD bus pins and a framebuffer RAM, for on-chip display emulation and for closing the loop around the LCD init sequencer in simulation.

## Interface
- COLS, 160: columns per page; column addresses ≥ COLS are out of range.
- PAGES, 72: pages; page addresses ≥ PAGES are out of range.
- clk  in  1  system clock; all bus inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- lcd_data  in  8  bus byte.
- lcd_cd  in  1  0 = command byte, 1 = display data byte.
- lcd_write  in  1  write strobe, active high.
- lcd_read  in  1  read strobe, active high. Reads are unsupported.
- lcd_cs  in  1  chip select, active high.
- fb_we  out  1  one-cycle framebuffer write pulse.
- fb_page  out  7  write page address.
- fb_col  out  8  write column address.
- fb_data  out  8  write data.
- cur_page  out  7  current page address counter, PA.
- cur_col  out  8  current column address counter, CA.
- scroll  out  8  SL[7:0].
- gray_lc  out  2  LC[6:5].
- map_ctl  out  3  {MY, MX, MSF}.
- bias  out  2  BR[1:0].
- panel_pc  out  2  PC[1:0].
- gain  out  2  GN[1:0].
- pot  out  6  PM[5:0].
- line_rate  out  2  LC[4:3].
- partial  out  2  LC[9:8].
- ram_ac  out  3  AC[2:0].
- apc  out  8  advanced product configuration value.
- disp_en  out  3  DC[4:2].
- cmd_err  out  1  one-cycle pulse on an illegal or unsupported bus event.

## Operation
- **Accept:**
  - A byte is accepted in the first cycle where lcd_write=1, the registered previous lcd_write=0, and lcd_cs=1.
  - lcd_data and lcd_cd are sampled in that same cycle.
  - The strobe is edge-detected, so a held-high lcd_write is accepted once.
  - lcd_write rising while lcd_cs=0 is ignored.
  - lcd_cs rising while lcd_write is already high is also ignored.
- **Argument state machine** (states ARG_NONE, ARG_GAIN, ARG_APC):
  - 0x81 moves to ARG_GAIN. The next command byte sets gain=byte[7:6] and pot=byte[5:0], then returns to ARG_NONE.
  - 0x30 and 0x31 move to ARG_APC. The next command byte sets apc=byte, then returns to ARG_NONE.
  - A data byte arriving in ARG_GAIN or ARG_APC: pulse cmd_err, return to ARG_NONE, then process the byte as data.
  - The argument state persists across lcd_cs deassertion.
- **Single-byte commands** (lcd_cd=0, ARG_NONE):
  - 0x0n → cur_col[3:0]=n.
  - 0x1n → cur_col[7:4]=n.
  - 0x28–0x2B → panel_pc.
  - 0x4n → scroll[3:0].
  - 0x5n → scroll[7:4].
  - 0x6n → cur_page[3:0].
  - 0x70–0x77 → cur_page[6:4].
  - 0x84–0x87 → partial.
  - 0x88–0x8F → ram_ac.
  - 0xA0–0xA3 → line_rate.
  - 0xA8–0xAF → disp_en.
  - 0xC0–0xC7 → map_ctl.
  - 0xD0–0xD3 → gray_lc.
  - 0xE8–0xEB → bias.
  - 0xE3 is a NOP.
  - 0xE2 is a system reset: all registers and the argument state return to reset values, and no fb_we is issued.
  - Any other opcode: cmd_err pulse, no register change.
- **Data byte** (lcd_cd=1):
  - If cur_page<PAGES and cur_col<COLS: fb_we=1, fb_page/fb_col = pre-increment address, fb_data=byte.
  - Otherwise the write is dropped silently.
  - The address advances in both cases.
- **Address advance:**
  - ram_ac[1]=0 (column-first): col+1. At col==COLS-1, col→0, and if ram_ac[0]=1, page+1.
  - ram_ac[1]=1 (page-first): page+1. At page==PAGES-1, page→0, and if ram_ac[0]=1, col+1.
  - The secondary counter wraps the same way: page at PAGES-1→0, col at COLS-1→0.
  - An out-of-range counter increments with natural 8-bit/7-bit wrap.
  - ram_ac[2] is stored only.
- **Read:** lcd_read=1 with lcd_cs=1 on its rising edge → cmd_err pulse; no other effect.
- **Reset values:**
  - All outputs 0, except bias=2'b11 and ram_ac=3'b001.
  - Argument state ARG_NONE.
  - fb_we=0 and cmd_err=0.

## Timing
- A byte accepted in cycle T has every register update, fb_* and cmd_err visible from cycle T+1.
- cur_col/cur_page show the post-increment address at T+1.
- fb_we and cmd_err are high for exactly one cycle.
- Maximum accept rate is one byte per 2 cycles: lcd_write must be low for ≥1 cycle between bytes.
- Asynchronous reset immediately forces all reset values, including fb_we=0, and aborts any pending argument. Reset dominates a simultaneous accept.
- A second rising edge in the same cycle as a pending fb_we is impossible, given the 2-cycle minimum spacing.

## Structure
- Shared package uc1611_pkg holds:
  - opcode constants and opcode masks;
  - the argument-state enum;
  - register reset defaults (bias, ram_ac).
- One sub-module is natural: uc1611_addr_gen.
  - Holds the page/column counters, the LSB/MSB loads, in-range check and increment/wrap logic.
  - Parameterised by COLS and PAGES.

## Test plan
- Reset, then the driver init sequence (0xD2, 0xC0, 0xEA, 0x2A, 0x81, 0x46, 0xA1, 0x84, 0x89, 0x31, 0x81, 0xAF, 0x40, 0x50, 0x60, 0x70, 0x00, 0x10) → gray_lc=2, bias=2, panel_pc=2, gain=1, pot=6, line_rate=1, ram_ac=1, apc=0x81, disp_en=7, addresses 0, no cmd_err.
- Data 0x02, 0x46, 0x8A, 0xCE at col 0/page 0 → four fb_we pulses at cols 0–3 with those values, cur_col=4.
- Column-first wrap: set col=159, page=71, ram_ac=1, write one data byte → fb write at (71,159), then cur_col=0, cur_page=0. Repeat with ram_ac=0 → cur_page stays 71.
- 0x81 followed by data byte 0x55 → cmd_err pulse, gain/pot unchanged, fb_we at the current address with 0x55.
- lcd_write held high for 5 cycles, lcd_write toggled with lcd_cs=0, and reset asserted between two bytes of 0x31/0x81 → at most one accept per edge, no accept when deselected, apc=0, and the next 0x81 is treated as a gain command.
- 0xE2 after arbitrary config → all registers back to reset values; unknown opcode 0xF0 → single cmd_err pulse.
